// File: rtl/div_pkg.sv
// Shared types and elaboration helpers for the sequential divider.
package div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ITER  = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } div_state_t;

  function automatic logic [31:0] min_neg(int w);
    return 32'h1 << (w - 1);
  endfunction

  function automatic int cnt_width(int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between a divider client and the divider.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dvz;
  logic             ovf;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  busy, valid, quotient, remainder, dvz, ovf
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output busy, valid, quotient, remainder, dvz, ovf
  );
endinterface

// File: rtl/seq_divider_dp.sv
// Restoring divide datapath: magnitude load, one quotient bit per
// iterate strobe, and sign correction of the result.
module seq_divider_dp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             iter_i,
  input  logic             fix_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic             negq_q;
  logic             negr_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             ge;

  always_comb begin
    a_neg   = signed_i & dividend_i[WIDTH-1];
    b_neg   = signed_i & divisor_i[WIDTH-1];
    mag_a   = a_neg ? -dividend_i : dividend_i;
    mag_b   = b_neg ? -divisor_i : divisor_i;
    shifted = {rem_q, quo_q[WIDTH-1]};
    // Extra top bit acts as the borrow of the trial subtraction
    diff    = shifted - {2'b00, dsr_q};
    ge      = ~diff[WIDTH+1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (load_i) begin
      rem_q  <= '0;
      quo_q  <= mag_a;
      dsr_q  <= mag_b;
      negq_q <= a_neg ^ b_neg;
      negr_q <= a_neg;
    end else if (iter_i) begin
      rem_q <= ge ? diff[WIDTH:0] : shifted[WIDTH:0];
      quo_q <= {quo_q[WIDTH-2:0], ge};
    end
  end

  always_comb begin
    quo_o = quo_q;
    rem_o = rem_q[WIDTH-1:0];
    if (fix_i && negq_q) quo_o = -quo_q;
    if (fix_i && negr_q) rem_o = -rem_q[WIDTH-1:0];
  end
endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: control FSM, iteration counter and
// held result registers around the shift/subtract datapath.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  seq_divider_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(min_neg(WIDTH));
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);

  div_state_t       state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sm_q;
  logic             busy_q;
  logic             valid_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             dvz_q;
  logic             ovf_q;

  logic             is_zero;
  logic             is_ovf;
  logic [WIDTH-1:0] dp_quo;
  logic [WIDTH-1:0] dp_rem;

  assign is_zero = (b_q == '0);
  assign is_ovf  = sm_q && (a_q == MIN_NEG) && (&b_q);

  seq_divider_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load_i    ((state_q == CHECK) && !is_zero && !is_ovf),
    .iter_i    (state_q == ITER),
    .fix_i     (state_q == FIX),
    .signed_i  (sm_q),
    .dividend_i(a_q),
    .divisor_i (b_q),
    .quo_o     (dp_quo),
    .rem_o     (dp_rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (bus.start) begin
          a_q     <= bus.dividend;
          b_q     <= bus.divisor;
          sm_q    <= bus.signed_mode;
          busy_q  <= 1'b1;
          state_q <= CHECK;
        end
        CHECK: begin
          if (is_zero) begin
            quo_q   <= '1;
            rem_q   <= a_q;
            dvz_q   <= 1'b1;
            ovf_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else if (is_ovf) begin
            quo_q   <= MIN_NEG;
            rem_q   <= '0;
            dvz_q   <= 1'b0;
            ovf_q   <= 1'b1;
            valid_q <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q   <= '0;
            state_q <= ITER;
          end
        end
        ITER: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) state_q <= FIX;
        end
        FIX: begin
          quo_q   <= dp_quo;
          rem_q   <= dp_rem;
          dvz_q   <= 1'b0;
          ovf_q   <= 1'b0;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.dvz       = dvz_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider at widths 8, 4, 16 and 32 against an arithmetic model.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int WS [4] = '{8, 4, 16, 32};

  logic        st [4];
  logic        sm;
  logic [31:0] a, b;
  logic [31:0] q [4];
  logic [31:0] r [4];
  logic        vl [4];
  logic        bs [4];
  logic        dz [4];
  logic        ov [4];

  int n_tests = 0;
  int n_fail  = 0;

  seq_divider_if #(.WIDTH(8))  i8 ();
  seq_divider_if #(.WIDTH(4))  i4 ();
  seq_divider_if #(.WIDTH(16)) i16 ();
  seq_divider_if #(.WIDTH(32)) i32 ();

  seq_divider #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(i8));
  seq_divider #(.WIDTH(4))  u4  (.clk(clk), .rst(rst), .bus(i4));
  seq_divider #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(i16));
  seq_divider #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(i32));

  assign i8.start  = st[0];
  assign i4.start  = st[1];
  assign i16.start = st[2];
  assign i32.start = st[3];
  assign i8.signed_mode  = sm;
  assign i4.signed_mode  = sm;
  assign i16.signed_mode = sm;
  assign i32.signed_mode = sm;
  assign i8.dividend  = a[7:0];
  assign i4.dividend  = a[3:0];
  assign i16.dividend = a[15:0];
  assign i32.dividend = a;
  assign i8.divisor   = b[7:0];
  assign i4.divisor   = b[3:0];
  assign i16.divisor  = b[15:0];
  assign i32.divisor  = b;

  assign q[0] = 32'(i8.quotient);
  assign q[1] = 32'(i4.quotient);
  assign q[2] = 32'(i16.quotient);
  assign q[3] = i32.quotient;
  assign r[0] = 32'(i8.remainder);
  assign r[1] = 32'(i4.remainder);
  assign r[2] = 32'(i16.remainder);
  assign r[3] = i32.remainder;
  assign vl[0] = i8.valid;
  assign vl[1] = i4.valid;
  assign vl[2] = i16.valid;
  assign vl[3] = i32.valid;
  assign bs[0] = i8.busy;
  assign bs[1] = i4.busy;
  assign bs[2] = i16.busy;
  assign bs[3] = i32.busy;
  assign dz[0] = i8.dvz;
  assign dz[1] = i4.dvz;
  assign dz[2] = i16.dvz;
  assign dz[3] = i32.dvz;
  assign ov[0] = i8.ovf;
  assign ov[1] = i4.ovf;
  assign ov[2] = i16.ovf;
  assign ov[3] = i32.ovf;

  // Truncating signed / plain unsigned division on 64-bit integers.
  task automatic model(input int w, input bit s, input logic [31:0] x,
                       input logic [31:0] y, output logic [31:0] mq,
                       output logic [31:0] mr, output bit mdz,
                       output bit mov);
    longint msk, sa, sb, qq, rr;
    msk = (longint'(1) << w) - 1;
    sa  = longint'(x) & msk;
    sb  = longint'(y) & msk;
    if (s && x[w-1]) sa = sa - (longint'(1) << w);
    if (s && y[w-1]) sb = sb - (longint'(1) << w);
    mdz = 0;
    mov = 0;
    if (sb == 0) begin
      mdz = 1; qq = msk; rr = sa;
    end else if (s && sa == -(longint'(1) << (w - 1)) && sb == -1) begin
      mov = 1; qq = sa; rr = 0;
    end else begin
      qq = sa / sb; rr = sa % sb;
    end
    mq = 32'(qq & msk);
    mr = 32'(rr & msk);
  endtask

  task automatic run_op(input int idx, input bit s, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eq,
                        input logic [31:0] er, input bit edz, input bit eov,
                        input string nm);
    int lat, got;
    lat = (edz || eov) ? 2 : WS[idx] + 3;
    got = 0;
    @(negedge clk);
    sm = s; a = x; b = y; st[idx] = 1'b1;
    @(posedge clk);
    #1 st[idx] = 1'b0;
    a = $urandom; b = $urandom; sm = ~s;
    for (int k = 1; k <= WS[idx] + 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_tests++;
        if (bs[idx] !== 1'b1) begin
          n_fail++;
          $display("FAIL %s busy_c1 got=%b exp=1", nm, bs[idx]);
        end
      end
      if (vl[idx] === 1'b1) begin
        got = k;
        break;
      end
    end
    n_tests++;
    if (got != lat) begin
      n_fail++;
      $display("FAIL %s latency got=%0d exp=%0d", nm, got, lat);
    end
    if (got != 0) begin
      n_tests++;
      if (q[idx] !== eq || r[idx] !== er || dz[idx] !== edz ||
          ov[idx] !== eov || bs[idx] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s result got q=%h r=%h dvz=%b ovf=%b busy=%b exp q=%h r=%h dvz=%b ovf=%b busy=1",
                 nm, q[idx], r[idx], dz[idx], ov[idx], bs[idx], eq, er, edz, eov);
      end
      @(negedge clk);
      n_tests++;
      if (vl[idx] !== 1'b0 || bs[idx] !== 1'b0 || q[idx] !== eq ||
          r[idx] !== er) begin
        n_fail++;
        $display("FAIL %s after_done got valid=%b busy=%b q=%h r=%h exp 0 0 %h %h",
                 nm, vl[idx], bs[idx], q[idx], r[idx], eq, er);
      end
    end
  endtask

  task automatic rand_op(input int idx, input bit s, input logic [31:0] x,
                         input logic [31:0] y, input string nm);
    logic [31:0] mq, mr;
    bit mdz, mov;
    model(WS[idx], s, x, y, mq, mr, mdz, mov);
    run_op(idx, s, x, y, mq, mr, mdz, mov, nm);
  endtask

  task automatic test_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (bs[i] !== 0 || vl[i] !== 0 || q[i] !== 0 || r[i] !== 0 ||
          dz[i] !== 0 || ov[i] !== 0) begin
        n_fail++;
        $display("FAIL reset_w%0d got busy=%b valid=%b q=%h r=%h dvz=%b ovf=%b exp all 0",
                 WS[i], bs[i], vl[i], q[i], r[i], dz[i], ov[i]);
      end
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    run_op(0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, "u100_7");
    run_op(0, 0, 32'd3, 32'd200, 32'd0, 32'd3, 0, 0, "u3_200");
  endtask

  task automatic test_signed();
    run_op(0, 1, 32'hF9, 32'h02, 32'hFD, 32'hFF, 0, 0, "s-7_2");
    run_op(0, 1, 32'h07, 32'hFE, 32'hFD, 32'h01, 0, 0, "s7_-2");
    run_op(0, 1, 32'hF9, 32'hFE, 32'h03, 32'hFF, 0, 0, "s-7_-2");
  endtask

  task automatic test_dvz();
    run_op(0, 0, 32'h5A, 32'h00, 32'hFF, 32'h5A, 1, 0, "dvz_u");
    run_op(0, 1, 32'h5A, 32'h00, 32'hFF, 32'h5A, 1, 0, "dvz_s");
  endtask

  task automatic test_ovf();
    run_op(0, 1, 32'h80, 32'hFF, 32'h80, 32'h00, 0, 1, "ovf_s");
    run_op(0, 0, 32'h80, 32'hFF, 32'h00, 32'h80, 0, 0, "ovf_u");
  endtask

  task automatic test_start_held();
    int vcnt, lcnt;
    vcnt = 0; lcnt = 0;
    @(negedge clk);
    sm = 0; a = 32'd100; b = 32'd7; st[0] = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (vl[0] === 1'b1) begin
        vcnt++;
        n_tests++;
        if (k % 12 != 11 || q[0] !== 32'd14) begin
          n_fail++;
          $display("FAIL held_valid got cycle=%0d q=%h exp cycle%%12=11 q=0e", k, q[0]);
        end
      end
      if (bs[0] !== 1'b1) begin
        lcnt++;
        n_tests++;
        if (k % 12 != 0) begin
          n_fail++;
          $display("FAIL held_idle got idle at cycle=%0d exp multiple of 12", k);
        end
      end
      if (k == 36) st[0] = 1'b0;
    end
    n_tests++;
    if (vcnt != 3 || lcnt != 3) begin
      n_fail++;
      $display("FAIL held_count got valids=%0d idles=%0d exp 3 3", vcnt, lcnt);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (bs[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL held_release got busy=%b exp 0", bs[0]);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    run_op(0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, "pre_rst");
    @(negedge clk);
    sm = 0; a = 32'd200; b = 32'd3; st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (bs[0] !== 0 || vl[0] !== 0 || q[0] !== 0 || r[0] !== 0 ||
        dz[0] !== 0 || ov[0] !== 0) begin
      n_fail++;
      $display("FAIL rst_mid got busy=%b valid=%b q=%h r=%h dvz=%b ovf=%b exp all 0",
               bs[0], vl[0], q[0], r[0], dz[0], ov[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (vl[0] !== 1'b0 || bs[0] !== 1'b0) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_novalid got active_cycles=%0d exp 0", seen);
    end
  endtask

  task automatic test_width_sweep();
    logic [31:0] mn, x, y;
    for (int i = 0; i < 4; i++) begin
      mn = 32'h1 << (WS[i] - 1);
      rand_op(i, 1, mn, 32'h1, "sw_mn_p1");
      rand_op(i, 1, mn, 32'hFFFF_FFFF, "sw_mn_m1");
      rand_op(i, 0, mn, 32'hFFFF_FFFF, "sw_mn_m1_u");
      rand_op(i, 1, 32'hFFFF_FFFF, mn, "sw_m1_mn");
      rand_op(i, 1, 32'h1, 32'hFFFF_FFFF, "sw_p1_m1");
      rand_op(i, 0, 32'd5, 32'hFFFF_FFFF, "sw_small");
      rand_op(i, 0, 32'hFFFF_FFFF, 32'h1, "sw_max_1");
      for (int n = 0; n < 25; n++) begin
        x = $urandom;
        y = $urandom;
        if ($urandom_range(0, 3) == 0) y = y >> $urandom_range(0, 31);
        if ($urandom_range(0, 9) == 0) y = 0;
        rand_op(i, 1'($urandom_range(0, 1)), x, y, "sw_rand");
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) st[i] = 1'b0;
    sm = 0; a = 0; b = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_dvz();
    test_ovf();
    test_start_held();
    test_reset_mid();
    test_width_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
